// File: rtl/l0_pkg.sv
// l0_pkg: shared read-mode encodings and default sizing for the skew buffer
//   MODE_PAR  : all rows read in the same cycle
//   MODE_STAG : row i read i cycles after row 0
package l0_pkg;
  typedef enum logic {MODE_PAR = 1'b0, MODE_STAG = 1'b1} mode_e;
  localparam int ROW_DEF = 8;
  localparam int BW_DEF = 4;
  localparam int DEPTH_DEF = 64;
  localparam int AF_MARGIN = 4;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_sync_row.sv
// fifo_sync_row: one synchronous row FIFO with a registered read port
//   clk, reset        : clock, sync active-high reset
//   wr, in            : push request and data (dropped when full)
//   rd                : pop request (ignored when empty)
//   out, o_valid      : registered read data and its one-cycle strobe
//   o_empty, o_full   : occupancy flags
//   o_count           : occupancy 0..DEPTH
module fifo_sync_row import l0_pkg::*; #(
  parameter int BW = BW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [BW-1:0]               in,
  output logic [BW-1:0]               out,
  output logic                        o_valid,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [cnt_w(DEPTH)-1:0]     o_count
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic [BW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [BW-1:0] r_out;
  logic          r_valid;
  logic          w_push, w_pop;
  // one extra pointer bit separates full from empty when the addresses match
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign w_push  = wr && !o_full;
  assign w_pop   = rd && !o_empty;
  assign o_count = r_wptr - r_rptr;
  assign out     = r_out;
  assign o_valid = r_valid;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-2:0]] <= in;
  end
  // pop reads pre-edge contents, so an empty row never forwards same-cycle write data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_out  <= r_mem[r_rptr[PW-2:0]];
      end
      r_valid <= w_pop;
    end
  end
endmodule

// File: rtl/l0_skew_buf.sv
// l0_skew_buf: ROW parallel FIFOs written together, read in parallel or staggered
//   clk, reset  : clock, sync active-high reset
//   wr, in      : push one word into every row (row i on in[BW*i +: BW])
//   rd, rd_mode : read request and mode (0 parallel, 1 staggered by row index)
//   out, o_valid: registered per-row read data and strobes
//   o_full, o_ready, o_afull, o_count : buffer flags, row-0 occupancy
//   o_ovf, o_udf: sticky overflow / underflow
module l0_skew_buf import l0_pkg::*; #(
  parameter int ROW = ROW_DEF,
  parameter int BW = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AF_LVL = DEPTH - AF_MARGIN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic [ROW*BW-1:0]         in,
  input  logic                      rd,
  input  logic                      rd_mode,
  output logic [ROW*BW-1:0]         out,
  output logic [ROW-1:0]            o_valid,
  output logic                      o_full,
  output logic                      o_ready,
  output logic                      o_afull,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_ovf,
  output logic                      o_udf
);
  localparam int CW = cnt_w(DEPTH);
  mode_e          r_mode;
  logic [ROW-1:0] r_rd_en, w_rd_nxt, w_empty, w_full;
  logic           w_wr;
  logic           r_ovf, r_udf;
  // rows share one accept decision so they never drift apart in content
  assign w_wr    = wr && !o_full;
  assign o_full  = |w_full;
  assign o_ready = &w_empty;
  assign o_afull = int'(o_count) >= AF_LVL;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;
  for (genvar g = 0; g < ROW; g++) begin : g_en
    if (g == 0) begin : g_head
      assign w_rd_nxt[g] = rd;
    end else begin : g_tail
      assign w_rd_nxt[g] = (r_mode == MODE_STAG) ? r_rd_en[g-1] : rd;
    end
  end
  // mode only changes while the read pipeline is idle, so a burst keeps its shape
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= MODE_PAR;
      r_rd_en <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (r_rd_en == '0 && !rd) r_mode <= mode_e'(rd_mode);
      r_rd_en <= w_rd_nxt;
      r_ovf   <= r_ovf | (wr & o_full);
      r_udf   <= r_udf | |(r_rd_en & w_empty);
    end
  end
  for (genvar g = 0; g < ROW; g++) begin : g_row
    logic [CW-1:0] w_cnt;
    fifo_sync_row #(.BW(BW), .DEPTH(DEPTH)) u_row (
      .clk     (clk),
      .reset   (reset),
      .wr      (w_wr),
      .rd      (r_rd_en[g]),
      .in      (in[g*BW +: BW]),
      .out     (out[g*BW +: BW]),
      .o_valid (o_valid[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g]),
      .o_count (w_cnt)
    );
    if (g == 0) begin : g_cnt
      assign o_count = w_cnt;
    end else begin : g_spare
      logic [CW-1:0] w_cnt_unused;
      assign w_cnt_unused = w_cnt;
    end
  end
endmodule

// File: tb/tb_l0_skew_buf.sv
// tb_l0_skew_buf: directed and random stimulus against a queue-based reference model
module tb_l0_skew_buf;
  localparam int ROW = 8, BW = 4, DEPTH = 64, CW = $clog2(DEPTH + 1);
  logic clk = 1'b0;
  logic reset = 1'b1, wr = 1'b0, rd = 1'b0, rd_mode = 1'b0;
  logic [ROW*BW-1:0] in = '0, out;
  logic [ROW-1:0] o_valid;
  logic o_full, o_ready, o_afull, o_ovf, o_udf;
  logic [CW-1:0] o_count;
  int checks = 0, failures = 0, cyc = 0;
  logic [BW-1:0] q [ROW][$];
  bit sched [ROW][256];
  logic [BW-1:0] m_out [ROW];
  logic [ROW-1:0] m_valid;
  bit m_ovf, m_udf, m_mode;

  l0_skew_buf dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .rd_mode(rd_mode),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .o_afull(o_afull), .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: per-row word queues plus a schedule of the cycles each row is read
  task automatic model_edge();
    bit full = 0, busy = 0;
    int s = cyc % 256;
    if (reset) begin
      for (int i = 0; i < ROW; i++) begin
        q[i].delete();
        m_out[i] = '0;
        for (int k = 0; k < 256; k++) sched[i][k] = 0;
      end
      m_valid = '0; m_ovf = 0; m_udf = 0; m_mode = 0;
    end else begin
      for (int i = 0; i < ROW; i++) begin
        if (q[i].size() == DEPTH) full = 1;
        if (sched[i][s]) busy = 1;
      end
      for (int i = 0; i < ROW; i++) begin
        m_valid[i] = 1'b0;
        if (sched[i][s]) begin
          if (q[i].size() > 0) begin
            m_out[i] = q[i].pop_front();
            m_valid[i] = 1'b1;
          end else m_udf = 1;
        end
      end
      if (wr && full) m_ovf = 1;
      if (wr && !full) for (int i = 0; i < ROW; i++) q[i].push_back(in[i*BW +: BW]);
      if (rd) for (int i = 0; i < ROW; i++) sched[i][(cyc + 1 + (m_mode ? i : 0)) % 256] = 1;
      if (!busy && !rd) m_mode = rd_mode;
      for (int i = 0; i < ROW; i++) sched[i][s] = 0;
    end
    cyc++;
  endtask

  task automatic step();
    logic [ROW*BW-1:0] e_out;
    bit e_full = 0, e_ready = 1;
    model_edge();
    @(posedge clk); #1;
    for (int i = 0; i < ROW; i++) begin
      e_out[i*BW +: BW] = m_out[i];
      if (q[i].size() == DEPTH) e_full = 1;
      if (q[i].size() != 0) e_ready = 0;
    end
    chk("out", out, e_out);
    chk("o_valid", o_valid, m_valid);
    chk("o_full", o_full, e_full);
    chk("o_ready", o_ready, e_ready);
    chk("o_afull", o_afull, q[0].size() >= DEPTH - 4);
    chk("o_count", o_count, q[0].size());
    chk("o_ovf", o_ovf, m_ovf);
    chk("o_udf", o_udf, m_udf);
  endtask

  task automatic do_reset();
    reset = 1; wr = 0; rd = 0;
    step();
    reset = 0;
  endtask

  task automatic put(input logic [ROW*BW-1:0] d);
    wr = 1; in = d;
    step();
    wr = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [ROW*BW-1:0] d;
    // reset state
    do_reset();
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_valid, 0);
    // parallel read of three words
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ROW; i++) d[i*BW +: BW] = BW'(i + 1 + k);
      put(d);
    end
    chk("par_cnt3", o_count, 3);
    rd = 1; step(); rd = 0; step();
    chk("par_valid", o_valid, 8'hFF);
    chk("par_out", out, 32'h8765_4321);
    chk("par_cnt2", o_count, 2);
    // staggered timing of a single word
    do_reset();
    rd_mode = 1; step();
    put(32'hA5A5_A5A5);
    rd = 1; step(); rd = 0;
    for (int j = 0; j < 9; j++) begin
      step();
      chk("stag_valid", o_valid, j < 8 ? (8'h01 << j) : 8'h00);
    end
    chk("stag_ready", o_ready, 1'b1);
    // fill, overflow, drain, wraparound
    do_reset();
    rd_mode = 0; step();
    for (int k = 1; k <= DEPTH; k++) begin
      put($urandom);
      chk("fill_afull", o_afull, k >= DEPTH - 4);
    end
    chk("fill_full", o_full, 1'b1);
    chk("fill_cnt", o_count, DEPTH);
    put($urandom);
    chk("ovf_set", o_ovf, 1'b1);
    chk("ovf_cnt", o_count, DEPTH);
    rd = 1; idle(DEPTH); rd = 0; idle(2);
    chk("drain_ready", o_ready, 1'b1);
    wr = 1; rd = 1;
    for (int k = 0; k < DEPTH + 2; k++) begin in = $urandom; step(); end
    wr = 0; idle(1);
    rd = 1; idle(3); rd = 0; idle(2);
    // underflow on an empty buffer, out holds previous data
    do_reset();
    put(32'h1357_9BDF);
    rd = 1; step(); rd = 0; idle(2);
    chk("udf_clear", o_udf, 1'b0);
    rd = 1; step(); rd = 0; step();
    chk("udf_valid", o_valid, 8'h00);
    chk("udf_out", out, 32'h1357_9BDF);
    chk("udf_set", o_udf, 1'b1);
    idle(5);
    chk("udf_sticky", o_udf, 1'b1);
    // mode change during a staggered burst is deferred
    do_reset();
    rd_mode = 1; step();
    for (int k = 0; k < 10; k++) put($urandom);
    rd = 1; rd_mode = 0; step(); step();
    chk("hold_stag", o_valid, 8'h01);
    step(); rd = 0;
    idle(12);
    rd = 1; step(); rd = 0; step();
    chk("mode_par", o_valid, 8'hFF);
    // reset in the middle of a staggered read
    do_reset();
    rd_mode = 1; step();
    for (int k = 0; k < 5; k++) put($urandom);
    rd = 1; step(); rd = 0; idle(2);
    reset = 1; wr = 1; rd = 1; step();
    chk("mrst_valid", o_valid, 8'h00);
    chk("mrst_cnt", o_count, 0);
    chk("mrst_ready", o_ready, 1'b1);
    chk("mrst_out", out, 0);
    reset = 0; wr = 0; rd = 0; idle(2);
    // random traffic
    for (int k = 0; k < 1500; k++) begin
      reset = $urandom_range(0, 199) == 0;
      wr = $urandom_range(0, 99) < 55;
      rd = $urandom_range(0, 99) < 45;
      if ($urandom_range(0, 19) == 0) rd_mode = ~rd_mode;
      in = $urandom;
      step();
    end
    reset = 0; wr = 0; rd = 0;
    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
